// File: rtl/qsd_to_bin.sv
// ---------------------------------------------------------------------------
// qsd_to_bin
//   Converts a quaternary-signed-digit (QSD) operand into 2*N_DIGITS-bit
//   two's-complement binary. The conversion is iterative Horner evaluation,
//   most significant digit first, consuming DPC digits per CONV cycle.
//   Both sides use a valid/ready handshake. Only one operand is in flight at
//   a time.
//
// Parameters
//   N_DIGITS  number of QSD digits per operand (output width 2*N_DIGITS)
//   DPC       digits consumed per CONV cycle (must divide N_DIGITS)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   qsd_in holds a valid operand
//   in_ready   block can accept an operand (state == IDLE)
//   qsd_in     digit i = qsd_in[3i+2:3i], 3-bit two's complement
//   out_valid  bin_out, ovf and dig_err are valid (state == DONE)
//   out_ready  downstream accepts the result
//   bin_out    two's-complement result (low 2N bits of the exact value)
//   ovf        exact value lies outside the signed 2N-bit range
//   dig_err    operand contained digit code 3'b100
//   busy       state != IDLE
//
// Configuration
//   QSD_DIGIT_CHECK_EN  when defined, digit code 3'b100 consumed during CONV
//                       sets a sticky dig_err (cleared on the next accept).
//                       When undefined, dig_err is tied to 0. In both builds
//                       3'b100 enters the accumulator as -4.
// ---------------------------------------------------------------------------
module qsd_to_bin #(
    parameter int N_DIGITS = 32,
    parameter int DPC      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3*N_DIGITS-1:0]   qsd_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*N_DIGITS-1:0]   bin_out,
    output logic                    ovf,
    output logic                    dig_err,
    output logic                    busy
);

    localparam int W     = 2 * N_DIGITS;         // result width
    localparam int AW    = W + 2;                // accumulator width, never wraps
    localparam int SW    = 3 * N_DIGITS;         // digit shift register width
    localparam int STEPS = N_DIGITS / DPC;       // CONV cycles per operand
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int SHIFT = 3 * DPC;
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [SW-1:0]          sr_r;
    logic signed [AW-1:0]   acc_r;
    logic signed [AW-1:0]   acc_s;
    logic [CW-1:0]          cnt_r;
    logic                   accept_s;
    logic                   last_s;

    // Sign-extend one 3-bit digit to accumulator width.
    function automatic logic signed [AW-1:0] digit_ext(input logic [2:0] d);
        return {{(AW-3){d[2]}}, d};
    endfunction

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);

    // Horner step: fold the DPC top digits of the shift register into acc.
    always_comb begin
        acc_s = acc_r;
        for (int j = 0; j < DPC; j++) begin
            acc_s = (acc_s <<< 2'd2) + digit_ext(sr_r[SW-1-3*j -: 3]);
        end
    end

    // Next-state decode and handshake events.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s  = CONV;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            CONV: begin
                if (cnt_r == LAST_CNT) begin
                    state_s = DONE;
                    last_s  = 1'b1;
                end else begin
                    state_s = CONV;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: operand capture, accumulation and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r    <= '0;
            acc_r   <= '0;
            cnt_r   <= '0;
            bin_out <= '0;
            ovf     <= 1'b0;
        end else if (accept_s) begin
            sr_r  <= qsd_in;
            acc_r <= '0;
            cnt_r <= '0;
        end else if (state_r == CONV) begin
            acc_r <= acc_s;
            sr_r  <= sr_r << SHIFT;
            cnt_r <= cnt_r + CW'(1);
            if (last_s) begin
                bin_out <= acc_s[W-1:0];
                // In range iff the bits from W-1 upward are all copies of the sign.
                ovf     <= ~((&acc_s[AW-1:W-1]) | ~(|acc_s[AW-1:W-1]));
            end
        end
    end

`ifdef QSD_DIGIT_CHECK_EN
    logic bad_digit_s;

    // Flag the illegal code 3'b100 among the digits consumed this cycle.
    always_comb begin
        bad_digit_s = 1'b0;
        for (int j = 0; j < DPC; j++) begin
            if (sr_r[SW-1-3*j -: 3] == 3'b100) begin
                bad_digit_s = 1'b1;
            end else begin
                bad_digit_s = bad_digit_s;
            end
        end
    end

    // Sticky digit-error flag, cleared when a new operand is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_err <= 1'b0;
        end else if (accept_s) begin
            dig_err <= 1'b0;
        end else if ((state_r == CONV) && bad_digit_s) begin
            dig_err <= 1'b1;
        end
    end
`else
    assign dig_err = 1'b0;
`endif

endmodule

// File: tb/tb_qsd_to_bin.sv
// ---------------------------------------------------------------------------
// tb_qsd_to_bin
//   Directed-vector bench for qsd_to_bin at the default parameters
//   (32 digits, 2 digits per cycle, 64-bit result). Expected values are
//   hand-computed constants or come from a binary->QSD encoder in the bench.
// ---------------------------------------------------------------------------
module tb_qsd_to_bin;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [95:0]  qsd_in;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  bin_out;
    logic         ovf;
    logic         dig_err;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    qsd_to_bin #(.N_DIGITS(32), .DPC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .qsd_in    (qsd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .ovf       (ovf),
        .dig_err   (dig_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] set_dig(input logic [95:0] q, input int i, input logic [2:0] d);
        logic [95:0] r;
        r = q;
        r[3*i +: 3] = d;
        return r;
    endfunction

    // Binary -> QSD: base-4 digits 0..3, top digit made signed (2,3 -> -2,-1).
    function automatic logic [95:0] encode(input logic [63:0] v);
        logic [95:0] q;
        logic [1:0]  d;
        q = 96'd0;
        for (int i = 0; i < 32; i++) begin
            d = v[2*i +: 2];
            if (i == 31) q[3*i +: 3] = {d[1], d};
            else         q[3*i +: 3] = {1'b0, d};
        end
        return q;
    endfunction

    // Present an operand and return after the accept edge.
    task automatic start_op(input logic [95:0] q);
        int t;
        t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check_eq("in_ready_timeout", 64'd0, 64'd1);
        in_valid = 1'b1;
        qsd_in   = q;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        qsd_in   = 96'd0;
    endtask

    // Count rising edges, including the accept edge, until out_valid rises.
    task automatic wait_done(output int lat);
        lat = 1;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid === 1'b1) break;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [95:0] q;
        logic [63:0] v;
        logic [63:0] held_bin;

        rst = 1'b1; in_valid = 1'b0; qsd_in = 96'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check_eq("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_busy",      {63'd0, busy},      64'd0);
        check_eq("rst_bin",       bin_out,            64'd0);

        // 1: d0 = d1 = 1 -> 5, latency 17
        q = set_dig(set_dig(96'd0, 0, 3'b001), 1, 3'b001);
        start_op(q);
        check_eq("t1_busy", {63'd0, busy}, 64'd1);
        wait_done(lat);
        check_eq("t1_latency", 64'(lat), 64'd17);
        check_eq("t1_bin", bin_out, 64'd5);
        check_eq("t1_ovf", {63'd0, ovf}, 64'd0);
        check_eq("t1_dig_err", {63'd0, dig_err}, 64'd0);
        finish_op();
        check_eq("t1_back_idle", {62'd0, in_ready, out_valid}, 64'd2);

        // 2: digits 0..30 = 3, d31 = -1 -> -1
        q = 96'd0;
        for (int i = 0; i < 31; i++) q = set_dig(q, i, 3'b011);
        q = set_dig(q, 31, 3'b111);
        start_op(q);
        wait_done(lat);
        check_eq("t2_bin", bin_out, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("t2_ovf", {63'd0, ovf}, 64'd0);
        finish_op();

        // 3: redundant form -1 + 4 -> 3
        q = set_dig(set_dig(96'd0, 0, 3'b111), 1, 3'b001);
        start_op(q);
        wait_done(lat);
        check_eq("t3_bin", bin_out, 64'd3);
        finish_op();

        // 4: d31 = 3 -> 3*2^62 overflows; then hold in DONE for 5 cycles
        q = set_dig(96'd0, 31, 3'b011);
        start_op(q);
        wait_done(lat);
        check_eq("t4_bin", bin_out, 64'hC000_0000_0000_0000);
        check_eq("t4_ovf", {63'd0, ovf}, 64'd1);
        held_bin = bin_out;
        in_valid = 1'b1;
        qsd_in   = set_dig(96'd0, 0, 3'b010);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("t5_hold_valid", {63'd0, out_valid}, 64'd1);
            check_eq("t5_hold_bin",   bin_out,            held_bin);
            check_eq("t5_hold_ovf",   {63'd0, ovf},       64'd1);
            check_eq("t5_hold_ready", {63'd0, in_ready},  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        qsd_in    = 96'd0;
        check_eq("t5_release", {62'd0, in_ready, out_valid}, 64'd2);

        // 6: reset 8 cycles into a conversion, then a clean operand of 5
        q = set_dig(96'd0, 0, 3'b101);
        start_op(q);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_eq("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("t6_rst_in_ready",  {63'd0, in_ready},  64'd1);
        check_eq("t6_rst_bin",       bin_out,            64'd0);
        q = set_dig(set_dig(96'd0, 0, 3'b001), 1, 3'b001);
        start_op(q);
        wait_done(lat);
        check_eq("t6_latency", 64'(lat), 64'd17);
        check_eq("t6_bin", bin_out, 64'd5);
        finish_op();

        // Digit code 3'b100 at d3 -> -4 * 64 = -256
        q = set_dig(96'd0, 3, 3'b100);
        start_op(q);
        wait_done(lat);
        check_eq("t6_neg4_bin", bin_out, 64'hFFFF_FFFF_FFFF_FF00);
`ifdef QSD_DIGIT_CHECK_EN
        check_eq("t6_dig_err", {63'd0, dig_err}, 64'd1);
`else
        check_eq("t6_dig_err", {63'd0, dig_err}, 64'd0);
`endif
        finish_op();

        // Random round trip through the bench encoder
        for (int n = 0; n < 1000; n++) begin
            v = {$urandom(), $urandom()};
            start_op(encode(v));
            wait_done(lat);
            check_eq("rand_bin", bin_out, v);
            check_eq("rand_ovf", {63'd0, ovf}, 64'd0);
            finish_op();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
